nios2_cpu_debug_cmd_sync: RTL and testbench
===========================================

# nios2_cpu_debug_cmd_sync

Parametrised successor to the debug module's system-clock half. It takes the virtual-JTAG update strobes (`vs_udr`, `vs_uir`) and the quasi-static `ir_in`/`sr` values from the TCK domain and synchronises the strobes into `clk`. Each captured command is queued in a FIFO of depth `FIFO_DEPTH`. Commands are released to the CPU debug logic through a valid/ready handshake as a one-hot `take_action` or `take_no_action` pulse, with the payload on `jdo`. Unlike the fixed 2-bit/38-bit, unbuffered predecessor, it is generic in IR width, DR width and synchroniser depth, it buffers back-to-back commands, and it reports overflow.

## Interface
Parameters:
- `IR_W`, default 2: virtual IR width. Number of action channels is `NCH = 2**IR_W`.
- `DR_W`, default 38: data-register (`sr`/`jdo`) width.
- `FIFO_DEPTH`, default 4: command queue depth, a power of two, at least 2.
- `SYNC_STAGES`, default 2: synchroniser flops per strobe, at least 2.

Ports:
- Clock and reset: one clock, `clk`. Reset `reset_n` is asynchronous and active-low.
- `clk`, input, 1: system clock.
- `reset_n`, input, 1: asynchronous active-low reset.
- `vs_udr`, input, 1: update-DR strobe, asynchronous to `clk`.
- `vs_uir`, input, 1: update-IR strobe, asynchronous to `clk`.
- `ir_in`, input, `IR_W`: current virtual IR; quasi-static.
- `sr`, input, `DR_W`: TCK shift register; quasi-static after update.
- `cmd_ready`, input, 1: consumer accepts the head entry.
- `ovf_clr`, input, 1: clears `overflow`.
- `cmd_valid`, output, 1: FIFO non-empty.
- `cmd_ir`, output, `IR_W`: IR of the head entry.
- `jdo`, output, `DR_W`: payload of the last popped entry; held until the next pop.
- `take_action`, output, `NCH`: one-hot 1-cycle pulse for a popped DR-update entry.
- `take_no_action`, output, `NCH`: one-hot 1-cycle pulse for a popped IR-update entry.
- `fifo_level`, output, `$clog2(FIFO_DEPTH)+1`: current occupancy.
- `overflow`, output, 1: sticky; a push was dropped.

## Operation
- Each strobe passes through `SYNC_STAGES` flops and then a rising-edge detector.
  - Synchroniser flops reset to 0; the edge-history flop resets to 1.
  - A strobe already high at reset release therefore produces no command.
- A `udr` edge pushes the entry {kind=ACT, `ir_in`, `sr`}. A `uir` edge pushes {kind=NOACT, `ir_in`, `sr`}.
- `ir_in` and `sr` are sampled on the push edge.
- Upstream contract: `ir_in` and `sr` must be held stable for at least `SYNC_STAGES+2` `clk` periods after the strobe rises. This holds by JTAG protocol, since no shift follows an update within that window.
- Simultaneous `udr` and `uir` edges in one cycle:
  - The `udr` entry is pushed first.
  - The `uir` edge is held in a 1-deep pending flag and pushed on the next cycle.
  - The `udr` push has priority over the pending flag as well.
- Pop occurs when `cmd_valid && cmd_ready`.
  - On the pop edge, `jdo` is loaded with the head `sr`.
  - On the same edge, `take_action[ir]` or `take_no_action[ir]` is set high for exactly one cycle, according to the entry's kind.
- Full FIFO:
  - A push with no concurrent pop is dropped and sets `overflow`.
  - A push with a concurrent pop is accepted, and the level is unchanged.
- Empty FIFO: `cmd_valid` is 0, `cmd_ready` is ignored, and no pulses are produced.
- Read and write pointers are `$clog2(FIFO_DEPTH)`-bit and wrap naturally. Level is tracked separately, in the range 0..`FIFO_DEPTH`.
- `overflow` is cleared by `ovf_clr`. A new drop in the same cycle wins, so `overflow` stays 1.

## Timing
- Reset values:
  - `cmd_valid`, `take_action`, `take_no_action`, `fifo_level` and `overflow` are 0.
  - `jdo` and `cmd_ir` are all-zero.
  - Pending flag is 0.
- Strobe to push: first `clk` edge sampling the strobe high is edge k. The push is at edge k+`SYNC_STAGES`. `cmd_valid` is high after that edge.
- Pop to outputs: the pulse and the new `jdo` appear after the pop edge, i.e. 1 cycle registered latency. Maximum rate is one pop per cycle.
- Reset asserted mid-operation: the queue is flushed immediately and all pulses are cancelled. Entries are not replayed after reset.

## Structure
- Package `nios2_cpu_debug_pkg` holds:
  - The entry-kind constants `KIND_ACT` and `KIND_NOACT`.
  - The default widths `IR_W=2` and `DR_W=38`.
  - Channel index names: `CH_OCIMEM=0`, `CH_TRACEMEM=1`, `CH_BREAK=2`, `CH_TRACECTRL=3`.
- Sub-module `nios2_cpu_debug_sync_edge`, parametrised by `SYNC_STAGES`: synchroniser plus rising-edge detector. It is instantiated twice, once per strobe.
- The FIFO is inline. Storage is a `FIFO_DEPTH` x (1+`IR_W`+`DR_W`) register array, with no RAM inference required.

## Test plan
- Single DR update: `ir_in`=2, `sr`=38'h2A_DEAD_BEEF, `vs_udr` pulsed, `cmd_ready`=1 → `cmd_valid` high after edge k+2, then `take_action`=4'b0100 for exactly 1 cycle, `jdo`=38'h2A_DEAD_BEEF, `fifo_level` returns to 0.
- IR update: `ir_in`=1, `vs_uir` pulsed → `take_no_action`=4'b0010 for 1 cycle, `take_action`=0.
- Backpressure and overflow: `cmd_ready`=0, 5 `udr` pulses with `sr`=1..5 → `fifo_level`=4, `overflow`=1. Then `cmd_ready`=1 → 4 pulses with `jdo` = 1, 2, 3, 4 in order; 5 is lost. Then `ovf_clr` → `overflow`=0.
- Full with simultaneous push and pop: level 4, push coincident with pop → level stays 4, `overflow` stays 0, pointer wrap correct over 3 full cycles of the FIFO.
- Simultaneous strobes: `udr` and `uir` rising in the same `clk` period → two entries, ACT then NOACT, on consecutive cycles; `fifo_level` reaches 2.
- Reset: assert `reset_n`=0 with level 3 → all outputs 0 asynchronously. Release with `vs_udr` held high → no push; the next fresh pulse is accepted normally.

Source files
------------

// File: rtl/nios2_cpu_debug_pkg.sv
// rtl/nios2_cpu_debug_pkg.sv - shared constants for the debug command synchroniser
package nios2_cpu_debug_pkg;

  localparam logic KIND_NOACT = 1'b0;
  localparam logic KIND_ACT   = 1'b1;

  localparam int IR_W_DEFAULT = 2;
  localparam int DR_W_DEFAULT = 38;

  localparam int CH_OCIMEM    = 0;
  localparam int CH_TRACEMEM  = 1;
  localparam int CH_BREAK     = 2;
  localparam int CH_TRACECTRL = 3;

endpackage

// File: rtl/nios2_cpu_debug_sync_edge.sv
// rtl/nios2_cpu_debug_sync_edge.sv - strobe synchroniser with rising-edge detector
module nios2_cpu_debug_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic strobe,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] primed_q;
  logic                   hist_q;

  // The history flop only follows the chain once the reset zeros have been
  // flushed, so a strobe already high at reset release never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '0;
      primed_q <= '0;
      hist_q   <= 1'b1;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], strobe};
      primed_q <= {primed_q[SYNC_STAGES-2:0], 1'b1};
      if (primed_q[SYNC_STAGES-1]) begin
        hist_q <= sync_q[SYNC_STAGES-1];
      end
    end
  end

  assign rise = primed_q[SYNC_STAGES-1] & sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/nios2_cpu_debug_cmd_sync.sv
// rtl/nios2_cpu_debug_cmd_sync.sv - TCK-to-clk debug command synchroniser with command queue
module nios2_cpu_debug_cmd_sync
  import nios2_cpu_debug_pkg::*;
#(
  parameter int  IR_W        = IR_W_DEFAULT,
  parameter int  DR_W        = DR_W_DEFAULT,
  parameter int  FIFO_DEPTH  = 4,
  parameter int  SYNC_STAGES = 2,
  localparam int NCH         = 2**IR_W,
  localparam int PTR_W       = $clog2(FIFO_DEPTH),
  localparam int LVL_W       = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             vs_udr,
  input  logic             vs_uir,
  input  logic [IR_W-1:0]  ir_in,
  input  logic [DR_W-1:0]  sr,
  input  logic             cmd_ready,
  input  logic             ovf_clr,
  output logic             cmd_valid,
  output logic [IR_W-1:0]  cmd_ir,
  output logic [DR_W-1:0]  jdo,
  output logic [NCH-1:0]   take_action,
  output logic [NCH-1:0]   take_no_action,
  output logic [LVL_W-1:0] fifo_level,
  output logic             overflow
);

  logic udr_rise;
  logic uir_rise;
  logic uir_pend_q;
  logic uir_pend_d;
  logic push;
  logic push_kind;
  logic full;
  logic pop;
  logic push_ok;
  logic drop;

  logic             mem_kind [FIFO_DEPTH];
  logic [IR_W-1:0]  mem_ir   [FIFO_DEPTH];
  logic [DR_W-1:0]  mem_sr   [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [NCH-1:0]   head_sel;

  nios2_cpu_debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .strobe  (vs_udr),
    .rise    (udr_rise)
  );

  nios2_cpu_debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .strobe  (vs_uir),
    .rise    (uir_rise)
  );

  // One push per cycle: a DR update always wins, a colliding IR update waits one slot.
  always_comb begin
    push       = 1'b0;
    push_kind  = KIND_ACT;
    uir_pend_d = uir_pend_q;
    if (udr_rise) begin
      push      = 1'b1;
      push_kind = KIND_ACT;
      if (uir_rise) begin
        uir_pend_d = 1'b1;
      end
    end else if (uir_pend_q) begin
      push       = 1'b1;
      push_kind  = KIND_NOACT;
      uir_pend_d = uir_rise;
    end else if (uir_rise) begin
      push      = 1'b1;
      push_kind = KIND_NOACT;
    end
  end

  assign cmd_valid = (fifo_level != '0);
  assign full      = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign pop       = cmd_valid & cmd_ready;
  assign push_ok   = push & (~full | pop);
  assign drop      = push & full & ~pop;
  assign cmd_ir    = mem_ir[rd_ptr];
  assign head_sel  = {{(NCH-1){1'b0}}, 1'b1} << mem_ir[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_kind[i] <= KIND_NOACT;
        mem_ir[i]   <= '0;
        mem_sr[i]   <= '0;
      end
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      fifo_level     <= '0;
      uir_pend_q     <= 1'b0;
      jdo            <= '0;
      take_action    <= '0;
      take_no_action <= '0;
      overflow       <= 1'b0;
    end else begin
      uir_pend_q <= uir_pend_d;
      if (push_ok) begin
        mem_kind[wr_ptr] <= push_kind;
        mem_ir[wr_ptr]   <= ir_in;
        mem_sr[wr_ptr]   <= sr;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      take_action    <= '0;
      take_no_action <= '0;
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        jdo    <= mem_sr[rd_ptr];
        if (mem_kind[rd_ptr] == KIND_ACT) begin
          take_action <= head_sel;
        end else begin
          take_no_action <= head_sel;
        end
      end
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nios2_cpu_debug_cmd_sync.sv
// tb/tb_nios2_cpu_debug_cmd_sync.sv - randomized self-checking bench against a queue-based model
module tb_nios2_cpu_debug_cmd_sync;

  localparam int IR_W  = 2;
  localparam int DR_W  = 38;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            vs_udr, vs_uir;
  logic [IR_W-1:0] ir_in;
  logic [DR_W-1:0] sr;
  logic            cmd_ready, ovf_clr;
  logic            cmd_valid;
  logic [IR_W-1:0] cmd_ir;
  logic [DR_W-1:0] jdo;
  logic [3:0]      take_action, take_no_action;
  logic [2:0]      fifo_level;
  logic            overflow;

  always #5 clk = ~clk;

  nios2_cpu_debug_cmd_sync #(
    .IR_W(IR_W), .DR_W(DR_W), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .vs_udr         (vs_udr),
    .vs_uir         (vs_uir),
    .ir_in          (ir_in),
    .sr             (sr),
    .cmd_ready      (cmd_ready),
    .ovf_clr        (ovf_clr),
    .cmd_valid      (cmd_valid),
    .cmd_ir         (cmd_ir),
    .jdo            (jdo),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .fifo_level     (fifo_level),
    .overflow       (overflow)
  );

  typedef struct {
    bit            act;
    bit [IR_W-1:0] ir;
    bit [DR_W-1:0] sr;
  } ent_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  ent_t          mq[$];
  int            udr_due[$];
  int            uir_due[$];
  int            uir_wait = 0;
  bit [DR_W-1:0] m_jdo = '0;
  bit            m_ovf = 1'b0;

  logic [3:0]      last_ta, last_tna;
  int              n_pulse;
  logic [DR_W-1:0] seen_jdo[$];
  bit              seen_act[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    udr_due.delete();
    uir_due.delete();
    uir_wait = 0;
    m_jdo    = '0;
    m_ovf    = 1'b0;
  endtask

  // Advance one clock, apply the queue model for that edge, then compare.
  task automatic step();
    bit         pop_m, full_pre, has_push, push_act, drop;
    ent_t       head, e;
    logic [3:0] exp_ta, exp_tna;
    @(posedge clk);
    cyc++;
    exp_ta   = '0;
    exp_tna  = '0;
    full_pre = (mq.size() == DEPTH);
    pop_m    = (mq.size() > 0) && cmd_ready;
    has_push = 1'b0;
    push_act = 1'b0;
    if (udr_due.size() > 0 && udr_due[0] == cyc) begin
      void'(udr_due.pop_front());
      has_push = 1'b1;
      push_act = 1'b1;
    end
    if (uir_due.size() > 0 && uir_due[0] == cyc) begin
      void'(uir_due.pop_front());
      uir_wait++;
    end
    if (!has_push && uir_wait > 0) begin
      uir_wait--;
      has_push = 1'b1;
    end
    if (pop_m) begin
      head  = mq.pop_front();
      m_jdo = head.sr;
      if (head.act) exp_ta = 4'b0001 << head.ir;
      else          exp_tna = 4'b0001 << head.ir;
    end
    drop = has_push && full_pre && !pop_m;
    if (has_push && !drop) begin
      e.act = push_act;
      e.ir  = ir_in;
      e.sr  = sr;
      mq.push_back(e);
    end
    if (drop)         m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    #1;
    check("level", fifo_level, mq.size());
    check("valid", cmd_valid, mq.size() != 0);
    check("overflow", overflow, m_ovf);
    check("take_action", take_action, exp_ta);
    check("take_no_action", take_no_action, exp_tna);
    check("jdo", jdo, m_jdo);
    if (mq.size() > 0) check("cmd_ir", cmd_ir, mq[0].ir);
    if (take_action != 0) last_ta = take_action;
    if (take_no_action != 0) last_tna = take_no_action;
    if ((take_action | take_no_action) != 0) begin
      n_pulse++;
      seen_jdo.push_back(jdo);
      seen_act.push_back(take_action != 0);
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit udr, input bit uir, input bit rdy, input bit clr,
                       input logic [IR_W-1:0] irv, input logic [DR_W-1:0] srv);
    if (reset_n && udr && !vs_udr) udr_due.push_back(cyc + 1 + SYNC);
    if (reset_n && uir && !vs_uir) uir_due.push_back(cyc + 1 + SYNC);
    vs_udr    = udr;
    vs_uir    = uir;
    cmd_ready = rdy;
    ovf_clr   = clr;
    ir_in     = irv;
    sr        = srv;
    step();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, rdy, 1'b0, ir_in, sr);
  endtask

  task automatic clear_seen();
    last_ta  = '0;
    last_tna = '0;
    n_pulse  = 0;
    seen_jdo.delete();
    seen_act.delete();
  endtask

  initial begin
    int last_rise;
    reset_n   = 1'b0;
    vs_udr    = 1'b0;
    vs_uir    = 1'b0;
    ir_in     = '0;
    sr        = '0;
    cmd_ready = 1'b0;
    ovf_clr   = 1'b0;
    repeat (2) step();
    check("rst_jdo", jdo, 0);
    check("rst_cmd_ir", cmd_ir, 0);
    reset_n = 1'b1;
    idle(5, 1'b1);

    // single DR update on the break channel
    clear_seen();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 38'h2A_DEAD_BEEF);
    idle(6, 1'b1);
    check("dr_ta", last_ta, 4'b0100);
    check("dr_pulses", n_pulse, 1);
    check("dr_jdo", jdo, 38'h2A_DEAD_BEEF);
    check("dr_level", fifo_level, 0);

    // IR update on the trace-memory channel
    clear_seen();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 38'h11);
    idle(6, 1'b1);
    check("ir_tna", last_tna, 4'b0010);
    check("ir_ta", last_ta, 4'b0000);
    check("ir_pulses", n_pulse, 1);

    // backpressure then overflow
    clear_seen();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, DR_W'(i));
      idle(3, 1'b0);
    end
    check("bp_level", fifo_level, 4);
    check("bp_ovf", overflow, 1);
    idle(6, 1'b1);
    check("bp_count", seen_jdo.size(), 4);
    for (int i = 0; i < 4 && i < seen_jdo.size(); i++) check("bp_order", seen_jdo[i], i + 1);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, sr);
    check("bp_clr", overflow, 0);

    // full queue with coincident push and pop across three wraps
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, DR_W'(10 + i));
      idle(2, 1'b0);
    end
    idle(2, 1'b0);
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 2'(i), DR_W'(100 + i));
      drive(1'b0, 1'b0, 1'b0, 1'b0, 2'(i), DR_W'(100 + i));
      drive(1'b0, 1'b0, 1'b1, 1'b0, 2'(i), DR_W'(100 + i));
      check("full_level", fifo_level, 4);
      check("full_ovf", overflow, 0);
    end
    clear_seen();
    idle(6, 1'b1);
    check("wrap_count", seen_jdo.size(), 4);
    for (int i = 0; i < 4 && i < seen_jdo.size(); i++) check("wrap_order", seen_jdo[i], 108 + i);

    // simultaneous strobes
    clear_seen();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 38'd77);
    idle(5, 1'b0);
    check("sim_level", fifo_level, 2);
    idle(4, 1'b1);
    check("sim_count", seen_act.size(), 2);
    if (seen_act.size() == 2) begin
      check("sim_first_act", seen_act[0], 1);
      check("sim_second_noact", seen_act[1], 0);
    end

    // asynchronous reset mid-operation, strobe held high across release
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd1, DR_W'(200 + i));
      idle(2, 1'b0);
    end
    idle(2, 1'b0);
    check("pre_rst_level", fifo_level, 3);
    #2;
    reset_n = 1'b0;
    vs_udr  = 1'b1;
    #1;
    model_clear();
    check("arst_level", fifo_level, 0);
    check("arst_valid", cmd_valid, 0);
    check("arst_jdo", jdo, 0);
    check("arst_pulses", take_action | take_no_action, 0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 38'd300);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 38'd300);
    check("held_no_push", fifo_level, 0);
    idle(2, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 38'd301);
    idle(3, 1'b0);
    check("fresh_push", fifo_level, 1);
    idle(4, 1'b1);

    // randomized traffic
    last_rise = cyc;
    for (int n = 0; n < 2000; n++) begin
      bit rdy, clr, u, v;
      int r;
      rdy = ($urandom_range(0, 99) < 55);
      clr = ($urandom_range(0, 99) < 3);
      u   = 1'b0;
      v   = 1'b0;
      if (cyc - last_rise >= 4 && $urandom_range(0, 99) < 45) begin
        r = $urandom_range(0, 9);
        u = (r < 6) || (r == 9);
        v = (r >= 6);
        last_rise = cyc;
        drive(u, v, rdy, clr, 2'($urandom), DR_W'({$urandom(), $urandom()}));
      end else begin
        drive(1'b0, 1'b0, rdy, clr, ir_in, sr);
      end
    end
    idle(12, 1'b1);
    check("end_level", fifo_level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
